// File: rtl/qflatten_pkg.sv
// Shared definitions for the queue flattener: skid buffer states and the eot level mapping.
package qflatten_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int MAX_LVL = 32;

  // Low din_lvl-dout_lvl+1 levels collapse into output level 0; higher levels shift down.
  function automatic logic [MAX_LVL-1:0] map_eot(input logic [MAX_LVL-1:0] din_eot,
                                                 input int din_lvl,
                                                 input int dout_lvl);
    logic [MAX_LVL-1:0] map;
    int f;
    map = '0;
    f   = din_lvl - dout_lvl;
    if (dout_lvl > 0) begin
      map[0] = 1'b1;
      for (int i = 0; i < MAX_LVL; i++) begin
        if (i <= f) map[0] = map[0] & din_eot[5'(i)];
      end
      for (int k = 1; k < MAX_LVL; k++) begin
        if (k < dout_lvl) map[5'(k)] = din_eot[5'(f + k)];
      end
    end
    return map;
  endfunction

endpackage

// File: rtl/dti_skid.sv
// Generic 2-entry skid buffer: 1-cycle latency, full rate; i_valid/o_ready upstream, o_valid/i_ready downstream.
// o_ready and o_valid depend only on the state flop (plus reset), so no combinational path crosses the stage.
module dti_skid import qflatten_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  skid_state_t  r_state;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         w_push;
  logic         w_pop;

  assign o_ready = rst & (r_state != FULL);
  assign o_valid = (r_state != EMPTY);
  assign o_data  = r_head;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  // r_head is always the element presented downstream; r_tail only holds the overflow entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_head  <= i_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_head <= i_data;
          end else if (w_push) begin
            r_tail  <= i_data;
            r_state <= FULL;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/qflatten_reg.sv
// Flattens the low eot levels of a dti queue and tags elements with a sub-transaction index.
// Latency 0 (REG_OUT=0, ready passes straight through) or 1 (REG_OUT=1, skid stage, registered ready).
module qflatten_reg import qflatten_pkg::*; #(
  parameter int TDIN     = 17,
  parameter int DIN_LVL  = 2,
  parameter int DOUT_LVL = 1,
  parameter int CNT_W    = 0,
  parameter int REG_OUT  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din_valid,
  output logic                           din_ready,
  input  logic [TDIN+DIN_LVL-1:0]        din_data,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [((CNT_W+TDIN+DOUT_LVL) > 0 ? (CNT_W+TDIN+DOUT_LVL) : 1)-1:0] dout_data
);

  localparam int DOUT_W  = CNT_W + TDIN + DOUT_LVL;
  localparam int DOUT_PW = (DOUT_W > 0) ? DOUT_W : 1;

  if (DIN_LVL < 1 || DOUT_LVL > DIN_LVL || DIN_LVL > MAX_LVL) begin : g_bad_cfg
    $error("qflatten_reg: need 1 <= DIN_LVL <= 32 and DOUT_LVL <= DIN_LVL");
  end

  logic [MAX_LVL-1:0] w_map;
  logic               w_last;
  logic               w_hs;
  logic               w_din_ready;
  logic [DOUT_PW-1:0] w_out;
  logic               w_unused_map;

  assign w_map        = map_eot(MAX_LVL'(din_data[TDIN+DIN_LVL-1:TDIN]), DIN_LVL, DOUT_LVL);
  assign w_last       = w_map[0];
  assign w_unused_map = ^w_map;
  assign w_hs         = din_valid & w_din_ready;
  assign din_ready    = w_din_ready;

  if (TDIN > 0) begin : g_data
    assign w_out[TDIN-1:0] = din_data[TDIN-1:0];
  end

  if (DOUT_LVL > 0) begin : g_eot
    assign w_out[TDIN +: DOUT_LVL] = w_map[DOUT_LVL-1:0];
  end

  // The element closing a sub-transaction keeps the pre-clear index; with no eot levels w_last is 0.
  if (CNT_W > 0) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (w_hs) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
    assign w_out[TDIN+DOUT_LVL +: CNT_W] = r_cnt;
  end

  if (DOUT_W == 0) begin : g_empty
    assign w_out = 1'b0;
  end

  if (REG_OUT != 0) begin : g_skid
    dti_skid #(.W(DOUT_PW)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_valid (din_valid),
      .o_ready (w_din_ready),
      .i_data  (w_out),
      .o_valid (dout_valid),
      .i_ready (dout_ready),
      .o_data  (dout_data)
    );
  end else begin : g_pass
    assign w_din_ready = dout_ready;
    assign dout_valid  = din_valid;
    assign dout_data   = w_out;
  end

endmodule

// File: tb/tb_qflatten_reg.sv
// Bench for qflatten_reg: three registered DUTs (DOUT_LVL 1/2/0) share one stimulus stream and are scoreboarded;
// a fourth payload-free passthrough instance is checked directly.
module tb_qflatten_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        din_valid;
  logic [10:0] din_data;
  logic        dout_ready;
  logic        rdy_a, rdy_b, rdy_c;
  logic        vld_a, vld_b, vld_c;
  logic [12:0] out_a;
  logic [13:0] out_b;
  logic [11:0] out_c;

  logic        d_din_valid, d_din_ready, d_dout_valid, d_dout_ready;
  logic [2:0]  d_din_data;
  logic [4:0]  d_dout_data;

  qflatten_reg #(.TDIN(8), .DIN_LVL(3), .DOUT_LVL(1), .CNT_W(4), .REG_OUT(1)) u_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy_a), .din_data(din_data),
    .dout_valid(vld_a), .dout_ready(dout_ready), .dout_data(out_a));
  qflatten_reg #(.TDIN(8), .DIN_LVL(3), .DOUT_LVL(2), .CNT_W(4), .REG_OUT(1)) u_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy_b), .din_data(din_data),
    .dout_valid(vld_b), .dout_ready(dout_ready), .dout_data(out_b));
  qflatten_reg #(.TDIN(8), .DIN_LVL(3), .DOUT_LVL(0), .CNT_W(4), .REG_OUT(1)) u_c (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy_c), .din_data(din_data),
    .dout_valid(vld_c), .dout_ready(dout_ready), .dout_data(out_c));
  qflatten_reg #(.TDIN(0), .DIN_LVL(3), .DOUT_LVL(1), .CNT_W(4), .REG_OUT(0)) u_d (
    .clk(clk), .rst(rst), .din_valid(d_din_valid), .din_ready(d_din_ready), .din_data(d_din_data),
    .dout_valid(d_dout_valid), .dout_ready(d_dout_ready), .dout_data(d_dout_data));

  int checks = 0;
  int errors = 0;
  logic [12:0] qa[$];
  logic [13:0] qb[$];
  logic [11:0] qc[$];
  int cnt_a, cnt_b, cnt_c;
  int acc_count = 0;
  int pop_count = 0;
  bit auto_rdy  = 0;
  bit rand_rdy  = 0;
  bit stream_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: idx = elements since the last closing element (mod 16); closing = all merged levels set.
  task automatic expect_elem(input logic [7:0] d, input logic [2:0] e);
    bit end_a, end_b;
    end_a = (e == 3'b111);
    end_b = (e[1:0] == 2'b11);
    qa.push_back({4'(cnt_a % 16), end_a, d});
    qb.push_back({4'(cnt_b % 16), e[2], end_b, d});
    qc.push_back({4'(cnt_c % 16), d});
    cnt_a = end_a ? 0 : cnt_a + 1;
    cnt_b = end_b ? 0 : cnt_b + 1;
    cnt_c = cnt_c + 1;
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    qc.delete();
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
  endtask

  // Called on a falling edge; returns on the falling edge after the element is accepted.
  task automatic send(input logic [7:0] d, input logic [2:0] e);
    bit done;
    done      = 0;
    din_valid = 1'b1;
    din_data  = {e, d};
    for (int t = 0; t < 100 && !done; t++) begin
      #1;
      if (rdy_a) begin
        check("ready_agree", 32'({rdy_b, rdy_c}), 32'({rdy_a, rdy_a}));
        expect_elem(d, e);
        acc_count++;
        done = 1;
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: data %h never accepted", d);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && (qa.size() + qb.size() + qc.size()) != 0; t++) @(negedge clk);
    check("drain_empty", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (auto_rdy) dout_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: an output transfers on the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    #2;
    if (vld_a && dout_ready) begin
      pop_count++;
      exp_v = (qa.size() > 0) ? 32'(qa.pop_front()) : 32'hDEAD_BEEF;
      check("out_a", 32'(out_a), exp_v);
    end
    if (vld_b && dout_ready) begin
      exp_v = (qb.size() > 0) ? 32'(qb.pop_front()) : 32'hDEAD_BEEF;
      check("out_b", 32'(out_b), exp_v);
    end
    if (vld_c && dout_ready) begin
      exp_v = (qc.size() > 0) ? 32'(qc.pop_front()) : 32'hDEAD_BEEF;
      check("out_c", 32'(out_c), exp_v);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, pbase;
    logic [2:0] e;
    rst = 1'b0;
    din_valid = 1'b0;
    din_data = '0;
    dout_ready = 1'b0;
    d_din_valid = 1'b0;
    d_din_data = '0;
    d_dout_ready = 1'b0;
    model_reset();

    @(negedge clk);
    #1;
    check("rst_valid", 32'({vld_a, vld_b, vld_c}), 32'd0);
    check("rst_ready", 32'({rdy_a, rdy_b, rdy_c}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    auto_rdy = 1;

    // Passthrough instance: combinational mapping and ready, index update on handshake.
    d_din_data = 3'b110;
    d_din_valid = 1'b1;
    d_dout_ready = 1'b0;
    #1;
    check("d_valid", 32'(d_dout_valid), 32'd1);
    check("d_map_110", 32'(d_dout_data), 32'h00);
    check("d_ready_lo", 32'(d_din_ready), 32'd0);
    d_dout_ready = 1'b1;
    #1;
    check("d_ready_hi", 32'(d_din_ready), 32'd1);
    @(negedge clk);
    #1;
    check("d_idx1", 32'(d_dout_data), 32'h02);
    d_din_data = 3'b111;
    #1;
    check("d_end", 32'(d_dout_data), 32'h03);
    @(negedge clk);
    #1;
    check("d_clear", 32'(d_dout_data), 32'h01);
    d_din_valid = 1'b0;
    d_dout_ready = 1'b0;
    #1;
    check("d_valid_lo", 32'(d_dout_valid), 32'd0);
    @(negedge clk);

    // Mapping patterns, then an index run of five closing on the fifth, then one more.
    send(8'hC3, 3'b011);
    send(8'h11, 3'b101);
    send(8'h5A, 3'b111);
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i), (i == 4) ? 3'b111 : 3'b000);
    drain();

    // Backpressure: consumer stalled for three cycles under a continuous stream.
    auto_rdy = 0;
    dout_ready = 1'b0;
    base = acc_count;
    stream_done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), 3'b000);
        stream_done = 1;
      end
    join_none
    repeat (3) @(negedge clk);
    check("bp_accepted", 32'(acc_count - base), 32'd2);
    check("bp_ready_low", 32'(rdy_a), 32'd0);
    dout_ready = 1'b1;
    auto_rdy = 1;
    pbase = pop_count;
    #3;
    repeat (5) @(negedge clk);
    #3;
    check("bp_no_gaps", 32'(pop_count - pbase), 32'd6);
    for (int t = 0; t < 50 && !stream_done; t++) @(negedge clk);
    check("bp_stream_done", 32'(stream_done), 32'd1);
    @(negedge clk);
    drain();

    // Reset while full, mid sub-transaction.
    auto_rdy = 0;
    dout_ready = 1'b0;
    send(8'hA1, 3'b000);
    send(8'hA2, 3'b000);
    check("full_valid", 32'(vld_a), 32'd1);
    check("full_ready", 32'(rdy_a), 32'd0);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_mid_valid", 32'({vld_a, vld_b, vld_c}), 32'd0);
    check("rst_mid_ready", 32'({rdy_a, rdy_b, rdy_c}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dout_ready = 1'b1;
    auto_rdy = 1;
    #1;
    check("rst_release_ready", 32'(rdy_a), 32'd1);

    // Seventeen non-closing elements: index wraps after 15.
    for (int i = 0; i < 17; i++) send(8'hE0 + 8'(i), 3'b000);
    drain();

    // Random traffic with random consumer stalls.
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      send(8'($urandom), e);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    rand_rdy = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
